// File: rtl/cfg_txn_driver.sv
// cfg_txn_driver: queued command port driving single cfg-bus write/read transactions.
// Each command holds cfg_enable for HOLD_CYCLES cycles, then pulses rsp_valid for one cycle.
// Optional read-data checking is compiled in with `define CFG_TXN_DRIVER_CHECK_EN; without it
// rsp_err_o and fail_cnt_o are tied to zero and cmd_exp_i/cmd_chk_i are ignored.
module cfg_txn_driver #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_rd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [DATA_W-1:0] cmd_exp_i,
    input  logic              cmd_chk_i,
    output logic              cfg_enable_o,
    output logic              cfg_rd_wr_o,
    output logic [ADDR_W-1:0] cfg_addr_o,
    output logic [DATA_W-1:0] cfg_wdata_o,
    input  logic [DATA_W-1:0] cfg_rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic [7:0]        fail_cnt_o
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    // Counter only needs to hold HOLD_CYCLES-1; keep at least one bit.
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef struct packed {
        logic              rd_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
`ifdef CFG_TXN_DRIVER_CHECK_EN
        logic [DATA_W-1:0] exp_data;
        logic              chk;
`endif
    } cmd_t;

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    cmd_t              mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    cmd_t              push_cmd, head_cmd;
    logic              push, pop;

    state_e            state_q;
    logic [HoldW-1:0]  hold_q;
    logic              cfg_enable_q, cfg_rd_wr_q;
    logic [ADDR_W-1:0] cfg_addr_q;
    logic [DATA_W-1:0] cfg_wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign push_cmd.rd_wr = cmd_rd_wr_i;
    assign push_cmd.addr  = cmd_addr_i;
    assign push_cmd.wdata = cmd_wdata_i;
`ifdef CFG_TXN_DRIVER_CHECK_EN
    assign push_cmd.exp_data = cmd_exp_i;
    assign push_cmd.chk      = cmd_chk_i;
`endif

    assign cmd_ready_o = (count_q != CntW'(DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    // The FSM takes the head whenever it is free to start a transaction (IDLE or RESP).
    assign pop         = (count_q != '0) && ((state_q == StIdle) || (state_q == StResp));
    assign head_cmd    = mem_q[rd_ptr_q];

    // Command storage; contents are don't-care while their slot is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

`ifdef CFG_TXN_DRIVER_CHECK_EN
    logic [DATA_W-1:0] exp_q;
    logic              chk_q;
    logic              rsp_err_q;
    logic [7:0]        fail_cnt_q;
    logic              mismatch;

    // Only checked reads can mismatch; evaluated on the final DRIVE cycle.
    assign mismatch   = chk_q && cfg_rd_wr_q && (cfg_rdata_i != exp_q);
    assign rsp_err_o  = rsp_err_q;
    assign fail_cnt_o = fail_cnt_q;
`else
    logic unused_chk_inputs;

    assign unused_chk_inputs = ^{cmd_exp_i, cmd_chk_i};
    assign rsp_err_o         = 1'b0;
    assign fail_cnt_o        = 8'd0;
`endif

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            cfg_enable_q <= 1'b0;
            cfg_rd_wr_q  <= 1'b0;
            cfg_addr_q   <= '0;
            cfg_wdata_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
`ifdef CFG_TXN_DRIVER_CHECK_EN
            exp_q        <= '0;
            chk_q        <= 1'b0;
            rsp_err_q    <= 1'b0;
            fail_cnt_q   <= 8'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef CFG_TXN_DRIVER_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
            unique case (state_q)
                StIdle, StResp: begin
                    cfg_enable_q <= 1'b0;
                    if (pop) begin
                        cfg_enable_q <= 1'b1;
                        cfg_rd_wr_q  <= head_cmd.rd_wr;
                        cfg_addr_q   <= head_cmd.addr;
                        cfg_wdata_q  <= head_cmd.wdata;
`ifdef CFG_TXN_DRIVER_CHECK_EN
                        exp_q        <= head_cmd.exp_data;
                        chk_q        <= head_cmd.chk;
`endif
                        hold_q       <= HoldW'(HOLD_CYCLES - 1);
                        state_q      <= StDrive;
                    end else begin
                        state_q      <= StIdle;
                    end
                end
                StDrive: begin
                    if (hold_q == '0) begin
                        cfg_enable_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_rdata_q  <= cfg_rd_wr_q ? cfg_rdata_i : '0;
`ifdef CFG_TXN_DRIVER_CHECK_EN
                        rsp_err_q    <= mismatch;
                        if (mismatch && (fail_cnt_q != 8'hFF)) begin
                            fail_cnt_q <= fail_cnt_q + 8'd1;
                        end
`endif
                        state_q      <= StResp;
                    end else begin
                        hold_q       <= hold_q - HoldW'(1);
                    end
                end
                default: begin
                    cfg_enable_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign cfg_enable_o = cfg_enable_q;
    assign cfg_rd_wr_o  = cfg_rd_wr_q;
    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_wdata_o  = cfg_wdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign busy_o       = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_cfg_txn_driver.sv
// Self-checking bench for cfg_txn_driver: scoreboard of expected transactions checked by a
// bus/response monitor, plus directed latency, full, saturation and reset checks.
module tb_cfg_txn_driver;

    localparam int unsigned Hold = 2;
`ifdef CFG_TXN_DRIVER_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    typedef struct {
        logic       rd;
        logic [2:0] addr;
        logic [9:0] wdata;
        logic [9:0] rdata;
        logic       err;
    } exp_t;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_rd_wr, cmd_chk;
    logic [2:0] cmd_addr;
    logic [9:0] cmd_wdata, cmd_exp;
    logic       cfg_enable, cfg_rd_wr;
    logic [2:0] cfg_addr;
    logic [9:0] cfg_wdata, cfg_rdata;
    logic       rsp_valid, rsp_err, busy;
    logic [9:0] rsp_rdata;
    logic [7:0] fail_cnt;
    logic [6:0] rd_hi;

    logic       b_cmd_valid, b_cmd_ready;
    logic [2:0] b_cmd_addr;
    logic [9:0] b_cmd_wdata;
    logic       b_cfg_enable, b_cfg_rd_wr, b_rsp_valid, b_rsp_err, b_busy;
    logic [2:0] b_cfg_addr;
    logic [9:0] b_cfg_wdata, b_cfg_rdata, b_rsp_rdata;
    logic [7:0] b_fail_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    exp_t sb[$];
    int   b_rsp_cycles[$];
    int   model_fail = 0;
    bit   gap_chk = 0;
    int   last_rsp = -1;
    bit   en_prev = 0;
    int   hi_len = 0;

    // Bus slave model: read data is the address with a settable upper field.
    assign cfg_rdata   = {rd_hi, cfg_addr};
    assign b_cfg_rdata = '0;

    cfg_txn_driver u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rd_wr_i(cmd_rd_wr),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_exp_i(cmd_exp),
        .cmd_chk_i(cmd_chk), .cfg_enable_o(cfg_enable), .cfg_rd_wr_o(cfg_rd_wr),
        .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata), .cfg_rdata_i(cfg_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .busy_o(busy), .fail_cnt_o(fail_cnt)
    );

    cfg_txn_driver #(.HOLD_CYCLES(1), .DEPTH(8)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_rd_wr_i(1'b0),
        .cmd_addr_i(b_cmd_addr), .cmd_wdata_i(b_cmd_wdata), .cmd_exp_i(10'd0),
        .cmd_chk_i(1'b0), .cfg_enable_o(b_cfg_enable), .cfg_rd_wr_o(b_cfg_rd_wr),
        .cfg_addr_o(b_cfg_addr), .cfg_wdata_o(b_cfg_wdata), .cfg_rdata_i(b_cfg_rdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
        .busy_o(b_busy), .fail_cnt_o(b_fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic rd, input logic [2:0] addr, input logic [9:0] wdata,
                        input logic [9:0] exp_d, input logic chk);
        exp_t e;
        int   w;
        cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = addr;
        cmd_wdata = wdata; cmd_exp = exp_d; cmd_chk = chk;
        w = 0;
        while (!cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        e.rd    = rd;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rd ? {rd_hi, addr} : 10'd0;
        e.err   = ChkEn && chk && rd && (e.rdata != exp_d);
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((busy || sb.size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("drain_busy", {31'd0, busy}, 32'd0);
        check("drain_sb", sb.size(), 32'd0);
    endtask

    // Monitor: bus fields at each strobe rise, hold length, response data/err/count.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            en_prev = 1'b0;
            hi_len  = 0;
        end else begin
            if (cfg_enable) begin
                if (!en_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_drive", 32'd1, 32'd0);
                    end else begin
                        check("bus_rd_wr", {31'd0, cfg_rd_wr}, {31'd0, sb[0].rd});
                        check("bus_addr", {29'd0, cfg_addr}, {29'd0, sb[0].addr});
                        check("bus_wdata", {22'd0, cfg_wdata}, {22'd0, sb[0].wdata});
                    end
                end
                hi_len++;
            end else if (en_prev) begin
                check("hold_len", hi_len, Hold);
                hi_len = 0;
            end
            if (rsp_valid) begin
                check("rsp_after_drive", {31'd0, en_prev && !cfg_enable}, 32'd1);
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.err && model_fail < 255) model_fail++;
                    check("rsp_rdata", {22'd0, rsp_rdata}, {22'd0, e.rdata});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("fail_cnt", {24'd0, fail_cnt}, model_fail);
                end
                if (gap_chk && last_rsp >= 0) check("b2b_gap", cycle - last_rsp, Hold + 1);
                last_rsp = cycle;
            end
            en_prev = cfg_enable;
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rsp_valid) b_rsp_cycles.push_back(cycle);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_exp = '0; cmd_chk = 1'b0; rd_hi = '0;
        b_cmd_valid = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_enable", {31'd0, cfg_enable}, 32'd0);
        check("rst_rd_wr", {31'd0, cfg_rd_wr}, 32'd0);
        check("rst_addr", {29'd0, cfg_addr}, 32'd0);
        check("rst_wdata", {22'd0, cfg_wdata}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {22'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_fail_cnt", {24'd0, fail_cnt}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write, exact latency from the accepting edge.
        push(1'b0, 3'd0, 10'd1, 10'd0, 1'b0);
        check("lat_en_n", {31'd0, cfg_enable}, 32'd0);
        check("lat_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_en_n1", {31'd0, cfg_enable}, 32'd1);
        @(negedge clk);
        check("lat_en_n2", {31'd0, cfg_enable}, 32'd1);
        @(negedge clk);
        check("lat_en_n3", {31'd0, cfg_enable}, 32'd0);
        check("lat_rsp", {31'd0, rsp_valid}, 32'd1);
        check("lat_rdata", {22'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        check("lat_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        check("lat_busy_end", {31'd0, busy}, 32'd0);
        check("bus_addr_hold", {29'd0, cfg_addr}, 32'd0);
        check("bus_wdata_hold", {22'd0, cfg_wdata}, 32'd1);

        // Back-to-back writes until the FIFO fills.
        gap_chk = 1'b1; last_rsp = -1;
        for (int i = 0; i < 6; i++) push(1'b0, 3'(i), 10'(i + 1), 10'd0, 1'b0);
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        wait_idle();
        gap_chk = 1'b0;

        // Checked reads: match, mismatch, unchecked mismatch, write with chk set.
        push(1'b1, 3'd3, 10'd0, 10'd3, 1'b1);
        wait_idle();
        push(1'b1, 3'd3, 10'd0, 10'd5, 1'b1);
        wait_idle();
        check("fail_cnt_one", {24'd0, fail_cnt}, ChkEn ? 32'd1 : 32'd0);
        rd_hi = 7'h5A;
        push(1'b1, 3'd6, 10'd0, 10'd0, 1'b0);
        wait_idle();
        rd_hi = 7'h00;
        push(1'b0, 3'd5, 10'h3FF, 10'd1, 1'b1);
        wait_idle();

        // Saturation of the mismatch counter.
        for (int i = 0; i < 300; i++) push(1'b1, 3'(i % 8), 10'd0, 10'(i % 8) ^ 10'h200, 1'b1);
        wait_idle();
        check("fail_cnt_sat", {24'd0, fail_cnt}, ChkEn ? 32'd255 : 32'd0);

        // Reset in the middle of DRIVE with two commands still queued.
        for (int i = 0; i < 3; i++) push(1'b0, 3'(7 - i), 10'(100 + i), 10'd0, 1'b0);
        check("pre_rst_drive", {31'd0, cfg_enable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_enable", {31'd0, cfg_enable}, 32'd0);
        check("midrst_rsp", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        model_fail = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check("postrst_busy", {31'd0, busy}, 32'd0);
        end

        // HOLD_CYCLES=1, DEPTH=8 instance: 8 queued writes, one completion every 2 cycles.
        for (int i = 0; i < 8; i++) begin
            b_cmd_valid = 1'b1; b_cmd_addr = 3'(i); b_cmd_wdata = 10'(i + 1);
            check("fast_ready", {31'd0, b_cmd_ready}, 32'd1);
            @(negedge clk);
        end
        b_cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("fast_rsp_count", b_rsp_cycles.size(), 32'd8);
        for (int i = 1; i < b_rsp_cycles.size(); i++)
            check("fast_gap", b_rsp_cycles[i] - b_rsp_cycles[i - 1], 32'd2);
        check("fast_busy", {31'd0, b_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
